// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: shared bus widths, FSM encoding, wait-counter width and request record for wb_ram.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_ram_pkg;

  localparam int ADR_WIDTH = 64;
  localparam int DAT_WIDTH = 64;
  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  // Wide enough for WAIT_STATES up to 15.
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One captured bus request.
  typedef struct packed {
    logic                 we;
    logic [SEL_WIDTH-1:0] sel;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
  } req_t;

  // Number of bytes covered by a RAM of 2**depth_log2 64-bit words.
  function automatic logic [ADR_WIDTH-1:0] ram_bytes(input int depth_log2);
    return 64'd8 << depth_log2;
  endfunction

endpackage

// File: rtl/wb_ram_mem.sv
// wb_ram_mem: single-port byte-enabled synchronous RAM, 64-bit words.
// Latency: 1 cycle; read data registered on the enabled edge and held until the next enabled read.
// Backpressure: none; one access per enabled cycle.
//
// Ports: clk_i/rst_i clock and async reset (clears the read register only, never the array);
// en_i/we_i/sel_i/adr_i/wdat_i access request; rdat_o registered read data.
module wb_ram_mem
  import wb_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [DEPTH_LOG2-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0]  wdat_i,
  output logic [DAT_WIDTH-1:0]  rdat_o
);

  logic [DAT_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (sel_i[i]) begin
          mem[adr_i][8*i +: 8] <= wdat_i[8*i +: 8];
        end
      end
    end
  end

  // Read register only changes on reads, so writes and errors leave it holding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdat_o <= '0;
    end else if (en_i && !we_i) begin
      rdat_o <= mem[adr_i];
    end
  end

endmodule

// File: rtl/wb_ram.sv
// wb_ram: Wishbone slave backing CPU instruction/data space with on-chip synchronous RAM.
// Latency: ack/err 1 + WAIT_STATES cycles after stb is first seen; at most one transaction every 2 cycles.
// Backpressure: master holds the request until ack/err; dropping cyc_i during wait states aborts.
//
// Ports: clk_i, rst_i (async, active-high); ram_cyc_i/ram_stb_i/ram_we_i/ram_sel_i/ram_adr_i/ram_dat_i
// request; ram_dat_o read data (valid with ack), ram_ack_o / ram_err_o one-cycle responses.
// Optional feature macro WB_RAM_ERR_EN: out-of-range or misaligned requests answer with ram_err_o
// instead of ram_ack_o and leave memory and ram_dat_o untouched; undefined, ram_err_o is tied 0
// and addresses alias modulo the RAM size.
module wb_ram
  import wb_ram_pkg::*;
#(
  parameter logic [ADR_WIDTH-1:0] BASE_ADR    = 64'h0000_8000_0000_0000,
  parameter int                   DEPTH_LOG2  = 12,
  parameter int                   WAIT_STATES = 0,
  parameter                       INIT_FILE   = ""
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ram_cyc_i,
  input  logic                 ram_stb_i,
  input  logic                 ram_we_i,
  input  logic [SEL_WIDTH-1:0] ram_sel_i,
  input  logic [ADR_WIDTH-1:0] ram_adr_i,
  input  logic [DAT_WIDTH-1:0] ram_dat_i,
  output logic [DAT_WIDTH-1:0] ram_dat_o,
  output logic                 ram_ack_o,
  output logic                 ram_err_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;
  localparam logic [ADR_WIDTH-1:0] RAM_BYTES = ram_bytes(DEPTH_LOG2);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  req_t                   req_q, req_in, req_cur;
  logic                   start;
  logic [ADR_WIDTH-1:0]   offset;
  logic [DEPTH_LOG2-1:0]  word_idx;
  logic                   req_bad;
  logic                   access;
  logic                   mem_en;
  logic                   ack_d, ack_q;

  assign start = ram_cyc_i & ram_stb_i;

  always_comb begin
    req_in     = '0;
    req_in.we  = ram_we_i;
    req_in.sel = ram_sel_i;
    req_in.adr = ram_adr_i;
    req_in.dat = ram_dat_i;
  end

  // With no wait states the access happens on the same edge that captures the
  // request, so the live bus values are used there; otherwise the captured copy.
  assign req_cur  = (state_q == ST_IDLE) ? req_in : req_q;
  assign offset   = req_cur.adr - BASE_ADR;
  assign word_idx = offset[DEPTH_LOG2+2:3];

`ifdef WB_RAM_ERR_EN
  assign req_bad = (req_cur.adr < BASE_ADR) || (offset >= RAM_BYTES) ||
                   (req_cur.adr[2:0] != 3'b000);
`else
  logic unused_offset_bits;
  assign req_bad            = 1'b0;
  assign unused_offset_bits = ^{offset[ADR_WIDTH-1:DEPTH_LOG2+3], offset[2:0], RAM_BYTES};
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RESP always falls back to IDLE, so a strobe still high
  // during RESP is not seen again until the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!ram_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the access fires on the edge entering RESP. Gating with
  // rst_i drops a write whose edge coincides with reset.
  always_comb begin
    access = (state_d == ST_RESP) && !rst_i;
    mem_en = access && !req_bad;
    ack_d  = access && !req_bad;
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      req_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      cnt_q <= CNT_INIT;
      req_q <= req_in;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign ram_ack_o = ack_q;

`ifdef WB_RAM_ERR_EN
  logic err_d, err_q;
  assign err_d = access && req_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ram_err_o = err_q;
`else
  assign ram_err_o = 1'b0;
`endif

  wb_ram_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (mem_en),
    .we_i   (req_cur.we),
    .sel_i  (req_cur.sel),
    .adr_i  (word_idx),
    .wdat_i (req_cur.dat),
    .rdat_o (ram_dat_o)
  );

endmodule

// File: tb/tb_wb_ram.sv
// tb_wb_ram: two wb_ram instances (0 and 3 wait states) driven with directed and random bus cycles.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_ram;

  localparam logic [63:0] BASE = 64'h0000_8000_0000_0000;
  localparam int          DL   = 8;
  localparam int          NW   = 1 << DL;
`ifdef WB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [7:0]  sel  [2];
  logic [63:0] adr  [2];
  logic [63:0] wdat [2];
  logic [63:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];

  logic [63:0] model    [2][NW];
  logic [63:0] last_dat [2];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  wb_ram #(.BASE_ADR(BASE), .DEPTH_LOG2(DL), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk_i(clk), .rst_i(rst), .ram_cyc_i(cyc[0]), .ram_stb_i(stb[0]), .ram_we_i(we[0]),
    .ram_sel_i(sel[0]), .ram_adr_i(adr[0]), .ram_dat_i(wdat[0]), .ram_dat_o(rdat[0]),
    .ram_ack_o(ack[0]), .ram_err_o(err[0]));

  wb_ram #(.BASE_ADR(BASE), .DEPTH_LOG2(DL), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .clk_i(clk), .rst_i(rst), .ram_cyc_i(cyc[1]), .ram_stb_i(stb[1]), .ram_we_i(we[1]),
    .ram_sel_i(sel[1]), .ram_adr_i(adr[1]), .ram_dat_i(wdat[1]), .ram_dat_o(rdat[1]),
    .ram_ack_o(ack[1]), .ram_err_o(err[1]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete bus cycle on instance d; stb is held through the response cycle.
  task automatic txn(input int d, input bit w, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] dv, output logic [63:0] got_dat);
    int          lat, seen, extra, idx;
    bit          bad, got_ack, got_err;
    logic [63:0] exp_dat;
    lat = (d == 0) ? 1 : 4;
    bad = ERR_EN && ((a < BASE) || (a >= BASE + (64'd8 << DL)) || (a[2:0] != 3'd0));
    idx = int'(((a - BASE) >> 3) & 64'(NW - 1));
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = dv;
    seen = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    for (int k = 1; k <= lat + 2 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) begin
        seen = k; got_ack = ack[d]; got_err = err[d]; got_dat = rdat[d];
      end
    end
    check($sformatf("d%0d latency a=%h", d, a), 64'(seen), 64'(lat));
    check($sformatf("d%0d ack a=%h", d, a), 64'(got_ack), 64'(!bad));
    check($sformatf("d%0d err a=%h", d, a), 64'(got_err), 64'(bad));
    if (!bad && !w) last_dat[d] = model[d][idx];
    exp_dat = last_dat[d];
    check($sformatf("d%0d dat a=%h", d, a), got_dat, exp_dat);
    extra = 0;
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (ack[d] || err[d]) extra++;
    @(posedge clk); #1;
    if (ack[d] || err[d]) extra++;
    check($sformatf("d%0d extra responses", d), 64'(extra), 64'd0);
    if (w && !bad) begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) model[d][idx][8*i +: 8] = dv[8*i +: 8];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g;
    logic [63:0] a;
    int          d, r;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; sel[i] = '0; adr[i] = '0; wdat[i] = '0;
      last_dat[i] = '0;
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d reset ack", i), 64'(ack[i]), 64'd0);
      check($sformatf("d%0d reset err", i), 64'(err[i]), 64'd0);
      check($sformatf("d%0d reset dat", i), rdat[i], 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < NW; j++) begin
        txn(i, 1'b1, BASE + 64'(8 * j), 8'hFF, {$urandom, $urandom}, g);
      end
    end

    // Directed cases on both instances.
    for (int i = 0; i < 2; i++) begin
      txn(i, 1'b1, BASE, 8'hFF, 64'h0200_0000_0000_0000, g);
      txn(i, 1'b0, BASE, 8'h00, 64'h0, g);
      check($sformatf("d%0d word0", i), g, 64'h0200_0000_0000_0000);
      txn(i, 1'b1, BASE + 8, 8'hFF, 64'h1122334455667788, g);
      txn(i, 1'b1, BASE + 8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, g);
      txn(i, 1'b0, BASE + 8, 8'h00, 64'h0, g);
      check($sformatf("d%0d lane merge", i), g, 64'h11223344_BBBBBBBB);
      txn(i, 1'b1, BASE + 16, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, g);
      txn(i, 1'b0, BASE + 16, 8'hFF, 64'h0, g);
      txn(i, 1'b0, BASE + (64'd8 << DL), 8'hFF, 64'h0, g);
`ifndef WB_RAM_ERR_EN
      check($sformatf("d%0d alias word0", i), g, 64'h0200_0000_0000_0000);
`endif
      txn(i, 1'b0, 64'h0, 8'hFF, 64'h0, g);
      txn(i, 1'b1, BASE + 4, 8'hFF, 64'h5555_6666_7777_8888, g);
      txn(i, 1'b0, BASE, 8'hFF, 64'h0, g);
    end

    // Abort: cyc drops during wait states on the 3-wait-state instance.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
    adr[1] = BASE + 40; wdat[1] = ~model[1][5];
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    r = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) r++;
    end
    check("abort responses", 64'(r), 64'd0);
    check("abort dat held", rdat[1], last_dat[1]);
    txn(1, 1'b0, BASE + 40, 8'hFF, 64'h0, g);

    // Reset in the middle of the wait states drops the write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 8'hFF;
    adr[1] = BASE + 56; wdat[1] = ~model[1][7];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst ack", 64'(ack[1]), 64'd0);
    check("rst err", 64'(err[1]), 64'd0);
    check("rst dat d1", rdat[1], 64'd0);
    check("rst dat d0", rdat[0], 64'd0);
    last_dat[0] = '0; last_dat[1] = '0;
    @(posedge clk); #1;
    rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    txn(1, 1'b0, BASE + 56, 8'hFF, 64'h0, g);

    // Random traffic.
    repeat (300) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r <= 6)      a = BASE + 64'(8 * $urandom_range(0, NW - 1));
      else if (r == 7) a = BASE + 64'(8 * $urandom_range(0, NW - 1)) + 64'($urandom_range(1, 7));
      else if (r == 8) a = BASE + (64'd8 << DL) + 64'(8 * $urandom_range(0, NW - 1));
      else             a = BASE - 64'(8 * $urandom_range(1, 64));
      txn(d, 1'($urandom_range(0, 1)), a,
          ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), {$urandom, $urandom}, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
